nibble_serial_adder: RTL and testbench



---
 rtl/nsa_pkg.sv | 12 +
 rtl/binary4.sv | 25 ++
 rtl/nibble_serial_adder.sv | 145 ++++++++++++++
 tb/tb_nibble_serial_adder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/binary4.sv
// 4-bit ripple-carry adder; one nibble slice of the wide serial add.
module binary4
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic                co,
  output logic [NIBBLE_W-1:0] s
);

  logic c;

  // Ripple the carry bit by bit through the nibble.
  always_comb begin
    c = cin;
    s = '0;
    for (int unsigned i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that walks operands one nibble per cycle through binary4,
// carrying between nibbles in a register; valid/ready on both sides.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic                       in_cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                       out_co,
  output logic                       busy
);

  localparam int unsigned W     = NIBBLE_W * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              co_q, co_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] add_s;
  logic                add_co;

  // Select the current nibble of each captured operand.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  binary4 u_binary4 (
    .a   (nib_a),
    .b   (nib_b),
    .cin (carry_q),
    .co  (add_co),
    .s   (add_s)
  );

  // Next-state and datapath updates for the accept/run/done sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    idx_d   = idx_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          idx_d   = '0;
          sum_d   = '0;
          co_d    = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*NIBBLE_W +: NIBBLE_W] = add_s;
          end
        end
        carry_d = add_co;
        if (idx_q == IDX_LAST) begin
          co_d    = add_co;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN) || (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      co_q        <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      co_q        <= co_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = sum_q;
  assign out_co    = co_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder (NIBBLES=4 and 1).
module tb_nibble_serial_adder;

  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_co, busy;
  logic [15:0] in_a, in_b, out_sum;

  logic        u_in_valid, u_in_ready, u_in_cin, u_out_valid, u_out_ready, u_out_co, u_busy;
  logic [3:0]  u_in_a, u_in_b, u_out_sum;

  int checks;
  int errors;
  int cyc;
  bit acc4;
  bit acc1;

  nibble_serial_adder #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_co(out_co), .busy(busy)
  );

  nibble_serial_adder #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_a(u_in_a), .in_b(u_in_b), .in_cin(u_in_cin),
    .out_valid(u_out_valid), .out_ready(u_out_ready),
    .out_sum(u_out_sum), .out_co(u_out_co), .busy(u_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: note which handshakes complete on this edge, then sample after it.
  task automatic tick();
    acc4 = in_ready && in_valid;
    acc1 = u_in_ready && u_in_valid;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: plain (W+1)-bit addition.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  task automatic accept4(input logic [15:0] a, input logic [15:0] b, input logic c, output int t0);
    int n;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    n = 0;
    tick();
    while (!acc4 && n < 50) begin tick(); n++; end
    if (!acc4) check("accept_timeout", 32'd0, 32'd1);
    t0 = cyc;
    in_valid = 1'b0;
    in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
  endtask

  task automatic wait_valid4();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    if (!out_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input int stall);
    logic [16:0] exp;
    int t0;
    exp = ref_add(a, b, c);
    out_ready = 1'b0;
    accept4(a, b, c, t0);
    wait_valid4();
    check("latency", 32'(cyc - t0), 32'd4);
    check("sum", 32'(out_sum), 32'(exp[15:0]));
    check("co", 32'(out_co), 32'(exp[16]));
    repeat (stall) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hs;
    logic        hc;
    int          t0;
    int          n;
    logic [16:0] e1;

    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    u_in_valid = 1'b0; u_in_a = '0; u_in_b = '0; u_in_cin = 1'b0; u_out_ready = 1'b0;
    #1 rst_n = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);
    check("rst_u_in_ready", 32'(u_in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_op(16'h0001, 16'h0003, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1);

    // Back-to-back with out_ready held high.
    out_ready = 1'b1;
    in_a = 16'h00FD; in_b = 16'h0003; in_cin = 1'b1; in_valid = 1'b1;
    n = 0;
    tick();
    while (!acc4 && n < 50) begin tick(); n++; end
    t0 = cyc;
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
    wait_valid4();
    check("b2b_lat1", 32'(cyc - t0), 32'd4);
    check("b2b_sum1", 32'(out_sum), 32'h0101);
    check("b2b_co1", 32'(out_co), 32'd0);
    n = 0;
    tick();
    while (!acc4 && n < 50) begin tick(); n++; end
    check("b2b_interval", 32'(cyc - t0), 32'd6);
    t0 = cyc;
    in_valid = 1'b0;
    wait_valid4();
    check("b2b_lat2", 32'(cyc - t0), 32'd4);
    check("b2b_sum2", 32'(out_sum), 32'hFFFF);
    check("b2b_co2", 32'(out_co), 32'd1);
    tick();
    out_ready = 1'b0;

    // Stall in DONE while upstream churns.
    e1 = ref_add(16'hABCD, 16'h9876, 1'b1);
    accept4(16'hABCD, 16'h9876, 1'b1, t0);
    wait_valid4();
    hs = out_sum; hc = out_co;
    check("stall_sum0", 32'(hs), 32'(e1[15:0]));
    check("stall_co0", 32'(hc), 32'(e1[16]));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
      tick();
      check("stall_sum", 32'(out_sum), 32'(hs));
      check("stall_co", 32'(out_co), 32'(hc));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of RUN.
    accept4(16'h1234, 16'h4321, 1'b0, t0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_co", 32'(out_co), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready2", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    run_op(16'h1234, 16'h4321, 1'b0, 0);

    // Randomized operations against the reference.
    for (int i = 0; i < 20; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Single-nibble instance.
    u_in_a = 4'hD; u_in_b = 4'h3; u_in_cin = 1'b1; u_in_valid = 1'b1;
    n = 0;
    tick();
    while (!acc1 && n < 50) begin tick(); n++; end
    t0 = cyc;
    u_in_valid = 1'b0; u_in_a = 4'h0; u_in_b = 4'h0;
    n = 0;
    while (!u_out_valid && n < 50) begin tick(); n++; end
    check("n1_latency", 32'(cyc - t0), 32'd1);
    check("n1_sum", 32'(u_out_sum), 32'h1);
    check("n1_co", 32'(u_out_co), 32'd1);
    u_out_ready = 1'b1;
    tick();
    u_out_ready = 1'b0;
    check("n1_in_ready", 32'(u_in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
